// File: rtl/lzs_pkg.sv
// Shared constants and FSM state type for the LZS compressed-input feeder.
package lzs_pkg;
  localparam int LZS_IN_WIDTH   = 13;
  localparam int LZS_WORD_WIDTH = 16;
  localparam int LZS_BUF_WIDTH  = 64;
  localparam int LZS_LZF_WIDTH  = 20;
  // A word may be popped only while it still fits below the valid bits.
  localparam int LZS_REFILL_TH  = LZS_BUF_WIDTH - LZS_WORD_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_RUN, ST_FLUSH, ST_DONE
  } state_t;
endpackage

// File: rtl/lzs_bit_shifter.sv
// Next-state shift buffer: drop consumed bits from the top, then OR a new
// word in directly below the bits that remain.
module lzs_bit_shifter
  import lzs_pkg::*;
#(
  parameter int BUF_WIDTH  = LZS_BUF_WIDTH,
  parameter int WORD_WIDTH = LZS_WORD_WIDTH
) (
  input  logic [BUF_WIDTH-1:0]              buf_q,
  input  logic [3:0]                        shift,
  input  logic                              ins_en,
  input  logic [$clog2(BUF_WIDTH+1)-1:0]    ins_pos,
  input  logic [WORD_WIDTH-1:0]             ins_word,
  output logic [BUF_WIDTH-1:0]              buf_d
);
  logic [BUF_WIDTH-1:0] shifted, word_ext;

  assign shifted  = buf_q << shift;
  assign word_ext = {ins_word, {(BUF_WIDTH-WORD_WIDTH){1'b0}}} >> ins_pos;
  assign buf_d    = ins_en ? (shifted | word_ext) : shifted;
endmodule

// File: rtl/lzs_stream_feeder.sv
// Feeds the LZS decoder a lookahead window from a 64-bit shift buffer filled
// with big-endian 16-bit words, and tracks the block's byte budget.
module lzs_stream_feeder
  import lzs_pkg::*;
#(
  parameter int IN_WIDTH   = LZS_IN_WIDTH,
  parameter int WORD_WIDTH = LZS_WORD_WIDTH,
  parameter int BUF_WIDTH  = LZS_BUF_WIDTH,
  parameter int LZF_WIDTH  = LZS_LZF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_decode,
  input  logic                  start,
  input  logic [LZF_WIDTH-1:0]  src_len,
  input  logic                  fi_valid,
  input  logic [WORD_WIDTH-1:0] fi_data,
  output logic                  fi_ack,
  output logic                  stream_valid,
  output logic [IN_WIDTH-1:0]   stream_data,
  input  logic                  stream_ack,
  input  logic [3:0]            stream_width,
  output logic                  stream_empty,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int CW = $clog2(BUF_WIDTH + 1);
  localparam logic [CW-1:0] IN_W      = CW'(IN_WIDTH);
  localparam logic [CW-1:0] REFILL_AT = CW'(BUF_WIDTH - WORD_WIDTH);
  localparam logic [CW-1:0] FULL_BITS = CW'(WORD_WIDTH);
  localparam logic [CW-1:0] HALF_BITS = CW'(WORD_WIDTH / 2);

  state_t                state;
  logic [BUF_WIDTH-1:0]  sbuf, buf_nxt;
  logic [CW-1:0]         left_q, width_ext, consumed, left_pc, left_nxt;
  logic [LZF_WIDTH-1:0]  words_rem, wr_nxt;
  logic                  odd_q, err_q;
  logic                  run_ok, cons, bad, take, pop, last_odd;
  logic [3:0]            shift_amt;
  logic [WORD_WIDTH-1:0] ins_word;

  assign width_ext    = CW'(stream_width);
  assign run_ok       = (state == ST_RUN) && (left_q >= IN_W);
  assign stream_valid = ce_decode && (run_ok || ((state == ST_FLUSH) && (left_q != '0)));
  assign stream_data  = sbuf[BUF_WIDTH-1 -: IN_WIDTH];

  assign cons      = stream_valid && stream_ack;
  assign bad       = cons && ((width_ext > left_q) || (width_ext > IN_W));
  assign take      = cons && !bad;
  assign consumed  = take ? width_ext : '0;
  assign shift_amt = take ? stream_width : 4'd0;
  assign left_pc   = left_q - consumed;

  // Refill sees the post-consume fill level so a word can land in the same cycle.
  assign fi_ack   = ce_decode && ((state == ST_LOAD) || (state == ST_RUN)) &&
                    (words_rem != '0) && (left_pc <= REFILL_AT);
  assign pop      = fi_ack && fi_valid;
  assign last_odd = odd_q && (words_rem == LZF_WIDTH'(1));
  assign ins_word = last_odd ? {fi_data[WORD_WIDTH-1 -: WORD_WIDTH/2], {(WORD_WIDTH/2){1'b0}}}
                             : fi_data;
  assign left_nxt = left_pc + (pop ? (last_odd ? HALF_BITS : FULL_BITS) : '0);
  assign wr_nxt   = words_rem - LZF_WIDTH'(pop);

  lzs_bit_shifter #(
    .BUF_WIDTH (BUF_WIDTH),
    .WORD_WIDTH(WORD_WIDTH)
  ) u_shifter (
    .buf_q   (sbuf),
    .shift   (shift_amt),
    .ins_en  (pop),
    .ins_pos (left_pc),
    .ins_word(ins_word),
    .buf_d   (buf_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sbuf      <= '0;
      left_q    <= '0;
      words_rem <= '0;
      odd_q     <= 1'b0;
      err_q     <= 1'b0;
    end else if (ce_decode) begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sbuf      <= '0;
            left_q    <= '0;
            err_q     <= 1'b0;
            words_rem <= {1'b0, src_len[LZF_WIDTH-1:1]} + LZF_WIDTH'(src_len[0]);
            odd_q     <= src_len[0];
            state     <= (src_len == '0) ? ST_DONE : ST_LOAD;
          end
        end
        default: begin
          if (bad) begin
            err_q     <= 1'b1;
            left_q    <= '0;
            sbuf      <= '0;
            words_rem <= '0;
            state     <= ST_DONE;
          end else begin
            sbuf      <= buf_nxt;
            left_q    <= left_nxt;
            words_rem <= wr_nxt;
            case (state)
              ST_LOAD: begin
                if ((left_nxt >= IN_W) || ((wr_nxt == '0) && (left_nxt != '0)))
                  state <= ST_RUN;
                else if (wr_nxt == '0)
                  state <= ST_DONE;
              end
              ST_RUN:   if (wr_nxt == '0) state <= ST_FLUSH;
              ST_FLUSH: if (left_nxt == '0) state <= ST_DONE;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign busy         = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_FLUSH);
  assign done         = (state == ST_DONE);
  assign stream_empty = (state == ST_DONE);
  assign err          = err_q;
endmodule

// File: tb/tb_lzs_stream_feeder.sv
// Randomized and directed bench for lzs_stream_feeder against a bit-queue model.
module tb_lzs_stream_feeder;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_FLUSH = 3, P_DONE = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        ce_decode = 1'b0, start = 1'b0;
  logic [19:0] src_len = '0;
  logic        fi_valid = 1'b0;
  logic [15:0] fi_data = '0;
  logic        fi_ack, stream_valid, stream_empty, busy, done, err;
  logic [12:0] stream_data;
  logic        stream_ack = 1'b0;
  logic [3:0]  stream_width = '0;

  int n_chk = 0, n_err = 0;
  logic [15:0] src_q[$];
  bit          bq[$];
  int          ph = P_IDLE, wleft = 0;
  bit          modd = 1'b0, merr = 1'b0;
  logic        o_sv, o_fa, o_dn, o_se, o_er, o_bz;
  logic [12:0] o_sd;

  lzs_stream_feeder dut (
    .clk(clk), .rst(rst), .ce_decode(ce_decode), .start(start), .src_len(src_len),
    .fi_valid(fi_valid), .fi_data(fi_data), .fi_ack(fi_ack),
    .stream_valid(stream_valid), .stream_data(stream_data), .stream_ack(stream_ack),
    .stream_width(stream_width), .stream_empty(stream_empty), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] window();
    logic [12:0] w = '0;
    for (int i = 0; i < 13; i++) w[12-i] = (i < bq.size()) ? bq[i] : 1'b0;
    return w;
  endfunction

  task automatic model_clear();
    bq.delete(); ph = P_IDLE; wleft = 0; modd = 1'b0; merr = 1'b0;
  endtask

  // One clock: drive at negedge, check against the model, then advance it.
  task automatic cyc(input bit st, input logic [19:0] len, input bit ce, input bit fv_en,
                     input bit ack, input logic [3:0] w);
    int sz, cons, nb;
    bit ev, ea, bd, fv;
    logic [15:0] wd;
    start = st; src_len = len; ce_decode = ce; stream_ack = ack; stream_width = w;
    fi_valid = fv_en && (src_q.size() > 0);
    fi_data  = (src_q.size() > 0) ? src_q[0] : 16'($urandom);
    #1;
    sz   = bq.size();
    ev   = ce && ((ph == P_RUN && sz >= 13) || (ph == P_FLUSH && sz > 0));
    bd   = ev && ack && (w > 13 || int'(w) > sz);
    cons = (ev && ack && !bd) ? int'(w) : 0;
    ea   = ce && (ph == P_LOAD || ph == P_RUN) && wleft > 0 && (sz - cons) <= 48;
    chk("stream_valid", stream_valid, ev);
    chk("stream_data", stream_data, window());
    chk("fi_ack", fi_ack, ea);
    chk("busy", busy, (ph == P_LOAD || ph == P_RUN || ph == P_FLUSH));
    chk("done", done, ph == P_DONE);
    chk("stream_empty", stream_empty, ph == P_DONE);
    chk("err", err, merr);
    o_sv = stream_valid; o_sd = stream_data; o_fa = fi_ack;
    o_dn = done; o_se = stream_empty; o_er = err; o_bz = busy;
    fv = fi_valid; wd = fi_data;
    @(posedge clk);
    if (ce) begin
      if ((ph == P_IDLE || ph == P_DONE) && st) begin
        merr = 1'b0; bq.delete();
        wleft = (int'(len) + 1) / 2; modd = len[0];
        ph = (len == 0) ? P_DONE : P_LOAD;
      end else if (bd) begin
        merr = 1'b1; bq.delete(); wleft = 0; ph = P_DONE;
      end else if (ph == P_LOAD || ph == P_RUN || ph == P_FLUSH) begin
        for (int i = 0; i < cons; i++) void'(bq.pop_front());
        if (ea && fv) begin
          nb = (wleft == 1 && modd) ? 8 : 16;
          for (int i = 0; i < nb; i++) bq.push_back(wd[15-i]);
          wleft--;
        end
        sz = bq.size();
        if (ph == P_LOAD) begin
          if (sz >= 13 || (wleft == 0 && sz > 0)) ph = P_RUN;
          else if (wleft == 0) ph = P_DONE;
        end else if (ph == P_RUN) begin
          if (wleft == 0) ph = P_FLUSH;
        end else if (sz == 0) ph = P_DONE;
      end
    end
    if (fv && ea && src_q.size() > 0) void'(src_q.pop_front());
    @(negedge clk);
  endtask

  task automatic rnd_cyc();
    int lim = (bq.size() < 13) ? bq.size() : 13;
    cyc(($urandom_range(0, 19) == 0), 20'($urandom_range(0, 40)), ($urandom_range(0, 9) != 0),
        ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 4'($urandom_range(0, lim)));
  endtask

  task automatic run_to_done(input int budget);
    int n = 0;
    while (ph != P_DONE && n < budget) begin rnd_cyc(); n++; end
    if (ph != P_DONE) chk("timeout", 0, 1);
    else chk("reached_done", done, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stream_ack = 1'b0; ce_decode = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; src_q.delete(); model_clear();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    cyc(0, 0, 1, 1, 0, 0);
    chk("reset_busy", o_bz, 0); chk("reset_data", o_sd, 0); chk("reset_empty", o_se, 0);

    // basic shift
    src_q = '{16'hA5C3, 16'h1234};
    cyc(1, 4, 1, 1, 0, 0); cyc(0, 0, 1, 1, 0, 0); cyc(0, 0, 1, 1, 0, 0);
    chk("basic_valid_T2", o_sv, 1); chk("basic_win_T2", o_sd, 13'h14B8);
    cyc(0, 0, 1, 1, 1, 9); cyc(0, 0, 1, 1, 0, 0);
    chk("basic_win_after9", o_sd, 13'h10C4);
    run_to_done(500);

    // odd length
    do_reset(); src_q = '{16'hFFFF, 16'hAB77};
    cyc(1, 3, 1, 1, 0, 0); cyc(0, 0, 1, 1, 0, 0); cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 1, 13); chk("odd_win0", o_sd, 13'h1FFF);
    cyc(0, 0, 1, 1, 1, 11); chk("odd_win1", o_sd, 13'h1EAC);
    cyc(0, 0, 1, 1, 0, 0);
    chk("odd_empty", o_se, 1); chk("odd_done", o_dn, 1); chk("odd_err", o_er, 0);

    // starvation
    do_reset(); src_q = '{16'hA5C3};
    cyc(1, 4, 1, 1, 0, 0); cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 1, 13); chk("starve_win", o_sd, 13'h14B8);
    cyc(0, 0, 1, 1, 0, 0); chk("starve_invalid0", o_sv, 0);
    cyc(0, 0, 1, 1, 0, 0); chk("starve_invalid1", o_sv, 0);
    src_q.push_back(16'h1234);
    cyc(0, 0, 1, 1, 0, 0); cyc(0, 0, 1, 1, 0, 0);
    chk("starve_resume_valid", o_sv, 1); chk("starve_resume_win", o_sd, 13'h0C48);
    run_to_done(500);

    // enable freeze mid-RUN
    do_reset(); src_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    cyc(1, 8, 1, 1, 0, 0); cyc(0, 0, 1, 1, 0, 0); cyc(0, 0, 1, 1, 0, 0);
    chk("freeze_pre_win", o_sd, 13'h0222);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 1, 5);
      chk("freeze_valid", o_sv, 0); chk("freeze_fi_ack", o_fa, 0);
    end
    cyc(0, 0, 1, 1, 0, 0);
    chk("freeze_post_valid", o_sv, 1); chk("freeze_post_win", o_sd, 13'h0222);
    run_to_done(500);

    // overrun in FLUSH
    do_reset(); src_q = '{16'hFFFF, 16'hAB77};
    cyc(1, 3, 1, 1, 0, 0); cyc(0, 0, 1, 1, 0, 0); cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 1, 13); cyc(0, 0, 1, 1, 1, 6); cyc(0, 0, 1, 1, 1, 8);
    src_q.push_back(16'h5A5A);
    cyc(1, 2, 1, 1, 0, 0);
    chk("ovr_err", o_er, 1); chk("ovr_done", o_dn, 1); chk("ovr_empty", o_se, 1);
    cyc(0, 0, 1, 1, 0, 0);
    chk("ovr_err_cleared", o_er, 0); chk("ovr_rearm_busy", o_bz, 1);
    run_to_done(500);

    // asynchronous reset mid-RUN
    do_reset(); src_q = '{16'hDEAD, 16'hBEEF, 16'hCAFE};
    cyc(1, 6, 1, 1, 0, 0); cyc(0, 0, 1, 1, 0, 0); cyc(0, 0, 1, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", stream_valid, 0); chk("arst_busy", busy, 0);
    chk("arst_fi_ack", fi_ack, 0); chk("arst_data", stream_data, 0);
    model_clear(); src_q.delete();
    @(negedge clk); rst = 1'b0;
    src_q = '{16'hBEEF};
    cyc(1, 2, 1, 1, 0, 0); cyc(0, 0, 1, 1, 0, 0); cyc(0, 0, 1, 1, 0, 0);
    chk("arst_new_win", o_sd, 13'h17DD);
    run_to_done(500);

    // randomized streams, re-armed from DONE
    for (int s = 0; s < 40; s++) begin
      int len = $urandom_range(0, 40);
      src_q.delete();
      for (int k = 0; k < (len + 1) / 2; k++) src_q.push_back(16'($urandom));
      cyc(1, 20'(len), 1, 1, 0, 0);
      run_to_done(1500);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/lzs_stream_feeder.md
Name: lzs_stream_feeder

Overview:
- Sequences the LZS decoder's compressed-input bitstream.
- Pops 16-bit big-endian words from an input FIFO into a 64-bit shift buffer.
- Presents the top IN_WIDTH bits to the decoder and retires a variable number of bits (stream_width) per acknowledged cycle.
- Tracks the byte budget of the block and signals end-of-stream (stream_empty) and completion to the host.

Parameters:
IN_WIDTH, 13, decoder lookahead window width in bits
WORD_WIDTH, 16, input FIFO word width
BUF_WIDTH, 64, shift buffer width
LZF_WIDTH, 20, width of the compressed byte-length field

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
ce_decode  in  1  global enable; low freezes all state
start  in  1  one-cycle pulse that begins a stream; honoured only in IDLE or DONE
src_len  in  LZF_WIDTH  compressed length in bytes, sampled on start
fi_valid  in  1  input FIFO word available
fi_data  in  WORD_WIDTH  input word; high byte is first in the stream
fi_ack  out  1  pop input FIFO (word taken when fi_valid & fi_ack)
stream_valid  out  1  stream_data holds decodable bits
stream_data  out  IN_WIDTH  buf[63:64-IN_WIDTH]; zero-padded below the valid bits
stream_ack  in  1  decoder consumes stream_width bits
stream_width  in  4  bits consumed, 0..IN_WIDTH
stream_empty  out  1  all bits consumed
busy  out  1  state is LOAD, RUN or FLUSH
done  out  1  state is DONE
err  out  1  sticky overrun or illegal width; cleared by start or rst

Behaviour:
- Reset (async, any state, including mid-stream):
  - state=IDLE; buf=0, left=0, words_rem=0, err=0.
  - All outputs 0.
- Registers:
  - buf[63:0]; left[6:0] (valid bit count, 0..64); words_rem (ceil(src_len/2)); odd flag (src_len[0]).
- Consume:
  - Occurs when stream_valid & stream_ack & ce_decode.
  - buf <<= stream_width; left -= stream_width.
- Refill:
  - fi_ack = ce_decode & state∈{LOAD,RUN} & words_rem>0 & (left - consumed_this_cycle) <= 48.
  - On pop, the word is ORed in at bit position 63 - (left - consumed) and left += 16.
  - The last word with odd=1 inserts only its high byte (low byte forced 0) and left += 8.
  - words_rem decrements on each pop.
  - Consume and refill in the same cycle: consume is applied first, then the insert lands at the post-consume position. At most one word per cycle.
- stream_data and stream_valid are combinational from registers. A consume at cycle N shows the shifted window at N+1.
- FSM:
  - IDLE:
    - start & src_len==0 → DONE.
    - start → LOAD; latch src_len, clear buf/left/err.
  - LOAD:
    - stream_valid=0; fetches words.
    - → RUN when left >= IN_WIDTH, or when words_rem==0 & left>0.
    - → DONE if words_rem==0 & left==0.
  - RUN:
    - stream_valid = left >= IN_WIDTH.
    - Starvation (fi_valid low, left < IN_WIDTH) drops stream_valid without a state change.
    - → FLUSH when words_rem==0 and no pop is pending.
  - FLUSH:
    - stream_valid = left > 0; the window is zero-padded.
    - left reaches 0 → DONE.
  - DONE:
    - stream_empty=1, done=1; holds until start.
    - start → LOAD, which re-arms the block.
- Errors:
  - Either condition sets err=1, forces left=0 and moves to DONE:
    - stream_width > left while acked;
    - stream_width > IN_WIDTH while acked.
- ce_decode=0:
  - stream_valid=0 and fi_ack=0.
  - No register changes except the async reset.
  - start is ignored.
- start in LOAD, RUN or FLUSH is ignored.
- Latency: start at T0 → first pop at T1 (if fi_valid) → stream_valid at T2.

Decomposition:
- Package lzs_pkg:
  - state enum (IDLE, LOAD, RUN, FLUSH, DONE);
  - IN_WIDTH, WORD_WIDTH, BUF_WIDTH and LZF_WIDTH defaults;
  - refill threshold BUF_WIDTH - WORD_WIDTH.
- Sub-module lzs_bit_shifter: combinational left-shift by stream_width plus word insert at a computed offset. The FSM and counters stay in lzs_stream_feeder.

Test Plan:
- Basic shift: src_len=4, words 0xA5C3, 0x1234, fi_valid=1.
  - stream_valid at T2 with stream_data=0x14B8.
  - Ack width 9 → next cycle stream_data=0x10C4.
- Odd length: src_len=3, words 0xFFFF, 0xAB77.
  - Only 24 bits are loaded; the low byte 0x77 is discarded.
  - Ack width 13 then 11 → stream_empty=1, done=1, err=0.
- Starvation: hold fi_valid=0 after the first word, then consume 13.
  - stream_valid=0 while left<13.
  - Raise fi_valid → stream_valid returns the next cycle with the correct window.
- Enable freeze: drop ce_decode for 5 cycles mid-RUN while stream_ack=1.
  - stream_valid=0, fi_ack=0; buf and left are unchanged.
  - Resumes the identical window afterwards.
- Overrun: in FLUSH with left=5, ack width 8 → err=1, DONE, stream_empty=1.
  - A following start clears err.
- Reset mid-RUN: assert rst between clock edges.
  - Outputs go 0 immediately; state is IDLE after release.
  - A new start with src_len=2 works normally.
